// File: rtl/ptmch_spi_frm_if.sv
// SPI snoop pins and the published frame record of ptmch_spi_frm.
// The sequencer is the slave: it watches the SPI lines and drives the record.
interface ptmch_spi_frm_if #(
  parameter int P_ABORT_W = 8
);
  logic                 SPI_CS;
  logic                 SPI_MOSI;
  logic                 SPI_MISO;
  logic [2:0]           FRM_CMD;
  logic [7:0]           FRM_OPC;
  logic [15:0]          FRM_ADDR;
  logic [7:0]           FRM_SR_ADDR;
  logic [7:0]           FRM_SR_DATA;
  logic                 FRM_TGL;
  logic [P_ABORT_W-1:0] ABORT_CNT;
  logic                 BUSY;

  modport slave (
    input  SPI_CS, SPI_MOSI, SPI_MISO,
    output FRM_CMD, FRM_OPC, FRM_ADDR, FRM_SR_ADDR, FRM_SR_DATA,
    output FRM_TGL, ABORT_CNT, BUSY
  );

  modport master (
    output SPI_CS, SPI_MOSI, SPI_MISO,
    input  FRM_CMD, FRM_OPC, FRM_ADDR, FRM_SR_ADDR, FRM_SR_DATA,
    input  FRM_TGL, ABORT_CNT, BUSY
  );
endinterface

// File: rtl/ptmch_spi_frm.sv
// SPI_CLK-domain frame sequencer for the SPI-NAND snoop path. Tracks each
// chip-select frame bit by bit, recognises the monitored opcodes, walks their
// argument fields and publishes a frame record with a toggle handshake.
module ptmch_spi_frm #(
  parameter logic [6:0] P_OPC_EN  = 7'h7F,
  parameter int         P_ABORT_W = 8
) (
  input  logic           RESET_N,
  input  logic           SPI_CLK,
  ptmch_spi_frm_if.slave bus
);

  typedef enum logic [2:0] {
    S_OPC, S_ARG1, S_ADDR, S_RDAT, S_WDAT, S_DONE, S_IGN
  } state_t;

  localparam logic [2:0] C_NONE = 3'd0;  // unknown or disabled opcode
  localparam logic [2:0] C_PEXE = 3'd1;  // program execute
  localparam logic [2:0] C_RDSR = 3'd2;  // read status
  localparam logic [2:0] C_BERS = 3'd3;  // 128KB block erase
  localparam logic [2:0] C_PRD  = 3'd4;  // page data read
  localparam logic [2:0] C_WRSR = 3'd5;  // write status

  // Opcode to command, honouring the per-opcode enable mask.
  function automatic logic [2:0] decode(input logic [7:0] op);
    logic [2:0] c;
    c = C_NONE;
    case (op)
      8'h10:   if (P_OPC_EN[0]) c = C_PEXE;
      8'h0F:   if (P_OPC_EN[1]) c = C_RDSR;
      8'h05:   if (P_OPC_EN[2]) c = C_RDSR;
      8'hD8:   if (P_OPC_EN[3]) c = C_BERS;
      8'h13:   if (P_OPC_EN[4]) c = C_PRD;
      8'h1F:   if (P_OPC_EN[5]) c = C_WRSR;
      8'h01:   if (P_OPC_EN[6]) c = C_WRSR;
      default: c = C_NONE;
    endcase
    return c;
  endfunction

  // Frame-local state is cleared while chip select is high.
  logic frm_rst_n;
  assign frm_rst_n = RESET_N & ~bus.SPI_CS;

  state_t         state, state_nxt;
  logic [4:0]     bit_cnt;
  // Seven history bits; together with the bit being sampled they form the
  // 8-bit shift window, so the completed byte is available on its last edge.
  logic [6:0]     shift;
  logic           busy;

  logic           din;
  logic [7:0]     shift_in;
  logic [2:0]     opc_cmd;
  logic           opc_hit, sr_addr_ld, addr_hi_ld, sr_data_ld, publish, abort;

  logic [2:0]     cmd_lat;
  logic [7:0]     opc_lat, sr_addr_lat, sr_data_lat, addr_hi;
  logic           pending;

  logic [2:0]     frm_cmd;
  logic [7:0]     frm_opc, frm_sr_addr, frm_sr_data;
  logic [15:0]    frm_addr;
  logic           frm_tgl;
  logic [P_ABORT_W-1:0] abort_cnt;

  assign din      = (state == S_RDAT) ? bus.SPI_MISO : bus.SPI_MOSI;
  assign shift_in = {shift, din};
  assign opc_cmd  = decode(shift_in);
  assign abort    = (state == S_OPC) && (bit_cnt == 5'd0) && pending && !bus.SPI_CS;

  // FSM state register, cleared by reset or chip select high.
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge SPI_CLK or negedge frm_rst_n) begin
    if (!frm_rst_n) state <= S_OPC;
    else            state <= state_nxt;
  end

  // Next-state and per-edge field strobes.
  // NOTE: every output of this block gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    opc_hit    = 1'b0;
    sr_addr_ld = 1'b0;
    addr_hi_ld = 1'b0;
    sr_data_ld = 1'b0;
    publish    = 1'b0;
    case (state)
      S_OPC: begin
        if (bit_cnt == 5'd7) begin
          if (opc_cmd != C_NONE) begin
            state_nxt = S_ARG1;
            opc_hit   = 1'b1;
          end else begin
            state_nxt = S_IGN;
          end
        end
      end
      S_ARG1: begin
        if (bit_cnt == 5'd15) begin
          case (cmd_lat)
            C_RDSR: begin
              state_nxt  = S_RDAT;
              sr_addr_ld = 1'b1;
            end
            C_WRSR: begin
              state_nxt  = S_WDAT;
              sr_addr_ld = 1'b1;
            end
            C_PEXE, C_BERS, C_PRD: state_nxt = S_ADDR;
            default:               state_nxt = S_IGN;
          endcase
        end
      end
      S_ADDR: begin
        if (bit_cnt == 5'd23) begin
          addr_hi_ld = 1'b1;
        end else if (bit_cnt == 5'd31) begin
          publish   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_RDAT, S_WDAT: begin
        if (bit_cnt == 5'd23) begin
          sr_data_ld = 1'b1;
        end else if (bit_cnt == 5'd31) begin
          publish   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = state;  // DONE and IGN wait for chip select high
    endcase
  end

  // Bit counter, shift window and BUSY, all frame-local.
  always_ff @(posedge SPI_CLK or negedge frm_rst_n) begin
    if (!frm_rst_n) begin
      bit_cnt <= 5'd0;
      shift   <= 7'd0;
      busy    <= 1'b0;
    end else begin
      if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      shift <= shift_in[6:0];
      if (opc_hit)      busy <= 1'b1;
      else if (publish) busy <= 1'b0;
    end
  end

  // Working copies of the fields, assembled while the frame runs.
  always_ff @(posedge SPI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_lat     <= C_NONE;
      opc_lat     <= 8'd0;
      sr_addr_lat <= 8'd0;
      sr_data_lat <= 8'd0;
      addr_hi     <= 8'd0;
    end else begin
      if (opc_hit) begin
        cmd_lat <= opc_cmd;
        opc_lat <= shift_in;
      end
      if (sr_addr_ld) sr_addr_lat <= shift_in;
      if (addr_hi_ld) addr_hi     <= shift_in;
      if (sr_data_ld) sr_data_lat <= shift_in;
    end
  end

  // Published record, handshake toggle and abort bookkeeping.
  // NOTE: these flops sit on RESET_N only; a chip-select rise must not wipe
  // the record the CLK160M side may still be reading.
  always_ff @(posedge SPI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frm_cmd     <= C_NONE;
      frm_opc     <= 8'd0;
      frm_addr    <= 16'd0;
      frm_sr_addr <= 8'd0;
      frm_sr_data <= 8'd0;
      frm_tgl     <= 1'b0;
      pending     <= 1'b0;
      abort_cnt   <= '0;
    end else begin
      if (publish) begin
        frm_cmd <= cmd_lat;
        frm_opc <= opc_lat;
        if (cmd_lat == C_RDSR || cmd_lat == C_WRSR) begin
          frm_sr_addr <= sr_addr_lat;
          frm_sr_data <= sr_data_lat;
        end else begin
          frm_addr <= {addr_hi, shift_in};
        end
        frm_tgl <= ~frm_tgl;
        pending <= 1'b0;
      end else if (opc_hit) begin
        pending <= 1'b1;
      end
      if (abort) begin
        pending <= 1'b0;
        if (abort_cnt != '1) abort_cnt <= abort_cnt + 1'b1;
      end
    end
  end

  assign bus.FRM_CMD     = frm_cmd;
  assign bus.FRM_OPC     = frm_opc;
  assign bus.FRM_ADDR    = frm_addr;
  assign bus.FRM_SR_ADDR = frm_sr_addr;
  assign bus.FRM_SR_DATA = frm_sr_data;
  assign bus.FRM_TGL     = frm_tgl;
  assign bus.ABORT_CNT   = abort_cnt;
  assign bus.BUSY        = busy;

endmodule

// File: tb/tb_ptmch_spi_frm.sv
// Bench for ptmch_spi_frm: directed vector table, hand sequences for abort
// saturation and mid-frame reset, then random frames against a frame-level
// model. Two instances run side by side: full opcode mask and one with 0x13
// disabled.
module tb_ptmch_spi_frm;

  logic spi_clk = 1'b0;
  logic rst_n;
  always #5 spi_clk = ~spi_clk;

  ptmch_spi_frm_if #(.P_ABORT_W(8)) if_a ();
  ptmch_spi_frm_if #(.P_ABORT_W(8)) if_b ();

  assign if_b.SPI_CS   = if_a.SPI_CS;
  assign if_b.SPI_MOSI = if_a.SPI_MOSI;
  assign if_b.SPI_MISO = if_a.SPI_MISO;

  ptmch_spi_frm #(.P_OPC_EN(7'h7F), .P_ABORT_W(8)) dut_a (
    .RESET_N (rst_n),
    .SPI_CLK (spi_clk),
    .bus     (if_a)
  );

  ptmch_spi_frm #(.P_OPC_EN(7'h6F), .P_ABORT_W(8)) dut_b (
    .RESET_N (rst_n),
    .SPI_CLK (spi_clk),
    .bus     (if_b)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [7:0]  opc;
    logic [15:0] addr;
    logic [7:0]  sra;
    logic [7:0]  srd;
    logic        tgl;
    logic [7:0]  abort;
    logic        pending;
    logic        busy;
  } rec_t;

  typedef struct {
    logic [31:0] mosi;
    logic [31:0] miso;
    int          nclk;
    logic [2:0]  cmd;
    logic [7:0]  opc;
    logic [15:0] addr;
    logic [7:0]  sra;
    logic [7:0]  srd;
    logic        tgl;
    logic [7:0]  abort;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;

  rec_t       mdl    [2];
  logic [6:0] mdl_en [2];

  logic [7:0] opc_tab [7] = '{8'h10, 8'h0F, 8'h05, 8'hD8, 8'h13, 8'h1F, 8'h01};
  logic [2:0] cmd_tab [7] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Command lookup straight from the opcode table and enable mask.
  function automatic logic [2:0] ref_cmd(input logic [7:0] op, input logic [6:0] en);
    logic [2:0] c;
    c = 3'd0;
    for (int j = 0; j < 7; j++)
      if (op == opc_tab[j] && en[j]) c = cmd_tab[j];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mdl[i].cmd = 3'd0;  mdl[i].opc = 8'd0;   mdl[i].addr = 16'd0;
      mdl[i].sra = 8'd0;  mdl[i].srd = 8'd0;   mdl[i].tgl = 1'b0;
      mdl[i].abort = 8'd0; mdl[i].pending = 1'b0; mdl[i].busy = 1'b0;
    end
  endtask

  // Effect of one whole frame of n clocks on the record.
  task automatic model_frame(input int i, input logic [31:0] mosi, input logic [31:0] miso,
                             input int n);
    logic [2:0] c;
    c = ref_cmd(mosi[31:24], mdl_en[i]);
    if (n >= 1 && mdl[i].pending) begin
      mdl[i].pending = 1'b0;
      if (mdl[i].abort != 8'hFF) mdl[i].abort = mdl[i].abort + 8'd1;
    end
    if (c != 3'd0 && n >= 8) begin
      if (n >= 32) begin
        mdl[i].cmd = c;
        mdl[i].opc = mosi[31:24];
        if (c == 3'd2 || c == 3'd5) begin
          mdl[i].sra = mosi[23:16];
          mdl[i].srd = (c == 3'd2) ? miso[15:8] : mosi[15:8];
        end else begin
          mdl[i].addr = mosi[15:0];
        end
        mdl[i].tgl = ~mdl[i].tgl;
      end else begin
        mdl[i].pending = 1'b1;
      end
    end
  endtask

  function automatic rec_t act_of(input int i);
    rec_t r;
    r.pending = 1'b0;
    if (i == 0) begin
      r.cmd = if_a.FRM_CMD;  r.opc = if_a.FRM_OPC;      r.addr = if_a.FRM_ADDR;
      r.sra = if_a.FRM_SR_ADDR; r.srd = if_a.FRM_SR_DATA; r.tgl = if_a.FRM_TGL;
      r.abort = if_a.ABORT_CNT; r.busy = if_a.BUSY;
    end else begin
      r.cmd = if_b.FRM_CMD;  r.opc = if_b.FRM_OPC;      r.addr = if_b.FRM_ADDR;
      r.sra = if_b.FRM_SR_ADDR; r.srd = if_b.FRM_SR_DATA; r.tgl = if_b.FRM_TGL;
      r.abort = if_b.ABORT_CNT; r.busy = if_b.BUSY;
    end
    return r;
  endfunction

  task automatic compare_rec(input string tag);
    rec_t a, e;
    for (int i = 0; i < 2; i++) begin
      a = act_of(i);
      e = mdl[i];
      check($sformatf("%s dut%0d cmd", tag, i),   32'(a.cmd),   32'(e.cmd));
      check($sformatf("%s dut%0d opc", tag, i),   32'(a.opc),   32'(e.opc));
      check($sformatf("%s dut%0d addr", tag, i),  32'(a.addr),  32'(e.addr));
      check($sformatf("%s dut%0d sra", tag, i),   32'(a.sra),   32'(e.sra));
      check($sformatf("%s dut%0d srd", tag, i),   32'(a.srd),   32'(e.srd));
      check($sformatf("%s dut%0d tgl", tag, i),   32'(a.tgl),   32'(e.tgl));
      check($sformatf("%s dut%0d abort", tag, i), 32'(a.abort), 32'(e.abort));
      check($sformatf("%s dut%0d busy", tag, i),  32'(a.busy),  32'(e.busy));
    end
  endtask

  task automatic cs_low(input logic [31:0] mosi, input logic [31:0] miso);
    @(negedge spi_clk);
    if_a.SPI_CS   = 1'b0;
    if_a.SPI_MOSI = mosi[31];
    if_a.SPI_MISO = miso[31];
  endtask

  // n rising edges; BUSY and FRM_TGL checked after each one.
  task automatic clock_bits(input logic [31:0] mosi, input logic [31:0] miso, input int n);
    rec_t a;
    for (int k = 1; k <= n; k++) begin
      @(posedge spi_clk);
      @(negedge spi_clk);
      for (int i = 0; i < 2; i++) begin
        logic known;
        known = (ref_cmd(mosi[31:24], mdl_en[i]) != 3'd0);
        a = act_of(i);
        check($sformatf("busy dut%0d clk%0d", i, k), 32'(a.busy),
              32'(known && k >= 8 && k <= 31));
        check($sformatf("tgl dut%0d clk%0d", i, k), 32'(a.tgl),
              32'(mdl[i].tgl ^ (known && k >= 32)));
      end
      if (k < 32) begin
        if_a.SPI_MOSI = mosi[31-k];
        if_a.SPI_MISO = miso[31-k];
      end else begin
        if_a.SPI_MOSI = 1'b0;
        if_a.SPI_MISO = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input logic [31:0] mosi, input logic [31:0] miso, input int n,
                           input string tag);
    cs_low(mosi, miso);
    clock_bits(mosi, miso, n);
    if_a.SPI_CS = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) model_frame(i, mosi, miso, n);
    compare_rec(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, mosi, miso;
    logic [7:0]  op;
    int          n;

    //           mosi          miso          n   cmd   opc    addr      sra    srd    tgl   abort
    vecs[0] = '{32'h10001234, 32'h00000000, 32, 3'd1, 8'h10, 16'h1234, 8'h00, 8'h00, 1'b1, 8'd0};
    vecs[1] = '{32'h0FC00000, 32'h00005A00, 32, 3'd2, 8'h0F, 16'h1234, 8'hC0, 8'h5A, 1'b0, 8'd0};
    vecs[2] = '{32'h01A07C00, 32'h00000000, 32, 3'd5, 8'h01, 16'h1234, 8'hA0, 8'h7C, 1'b1, 8'd0};
    vecs[3] = '{32'hD8FF0040, 32'h00000000, 32, 3'd3, 8'hD8, 16'h0040, 8'hA0, 8'h7C, 1'b0, 8'd0};
    vecs[4] = '{32'h9F000000, 32'h00000000, 32, 3'd3, 8'hD8, 16'h0040, 8'hA0, 8'h7C, 1'b0, 8'd0};
    vecs[5] = '{32'h13000000, 32'h00000000, 12, 3'd3, 8'hD8, 16'h0040, 8'hA0, 8'h7C, 1'b0, 8'd0};
    vecs[6] = '{32'h1300ABCD, 32'h00000000, 32, 3'd4, 8'h13, 16'hABCD, 8'hA0, 8'h7C, 1'b1, 8'd1};

    mdl_en[0] = 7'h7F;
    mdl_en[1] = 7'h6F;
    model_reset();

    rst_n         = 1'b1;
    if_a.SPI_CS   = 1'b1;
    if_a.SPI_MOSI = 1'b0;
    if_a.SPI_MISO = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge spi_clk);
    compare_rec("reset");
    rst_n = 1'b1;

    // Directed vectors, checked against the model and the table constants.
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].mosi, vecs[v].miso, vecs[v].nclk, $sformatf("vec%0d", v));
      check($sformatf("vec%0d tab cmd", v),   32'(if_a.FRM_CMD),     32'(vecs[v].cmd));
      check($sformatf("vec%0d tab opc", v),   32'(if_a.FRM_OPC),     32'(vecs[v].opc));
      check($sformatf("vec%0d tab addr", v),  32'(if_a.FRM_ADDR),    32'(vecs[v].addr));
      check($sformatf("vec%0d tab sra", v),   32'(if_a.FRM_SR_ADDR), 32'(vecs[v].sra));
      check($sformatf("vec%0d tab srd", v),   32'(if_a.FRM_SR_DATA), 32'(vecs[v].srd));
      check($sformatf("vec%0d tab tgl", v),   32'(if_a.FRM_TGL),     32'(vecs[v].tgl));
      check($sformatf("vec%0d tab abort", v), 32'(if_a.ABORT_CNT),   32'(vecs[v].abort));
    end

    // 300 cut-short page reads drive the abort counter into saturation.
    for (int j = 0; j < 300; j++) begin
      r = $urandom();
      run_frame({8'h13, r[23:0]}, 32'h0, 12, $sformatf("sat%0d", j));
    end
    check("abort saturated", 32'(if_a.ABORT_CNT), 32'hFF);
    check("abort disabled opcode", 32'(if_b.ABORT_CNT), 32'h0);

    // Reset in the middle of a page read, then a normal frame.
    cs_low(32'h13001234, 32'h0);
    clock_bits(32'h13001234, 32'h0, 20);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_rec("midrst");
    check("midrst abort", 32'(if_a.ABORT_CNT), 32'h0);
    @(negedge spi_clk);
    if_a.SPI_CS = 1'b1;
    rst_n       = 1'b1;
    run_frame(32'h10005678, 32'h0, 32, "postrst");
    check("postrst tgl", 32'(if_a.FRM_TGL), 32'h1);
    check("postrst addr", 32'(if_a.FRM_ADDR), 32'h5678);
    check("postrst abort", 32'(if_a.ABORT_CNT), 32'h0);

    // Random frames: mostly monitored opcodes, mixed lengths including 0 and >32.
    for (int j = 0; j < 150; j++) begin
      r = $urandom();
      if ($urandom_range(0, 3) == 0) op = r[31:24];
      else                           op = opc_tab[$urandom_range(0, 6)];
      mosi = {op, r[23:0]};
      miso = $urandom();
      if ($urandom_range(0, 2) == 0) n = $urandom_range(0, 40);
      else                           n = 32;
      run_frame(mosi, miso, n, $sformatf("rnd%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
